// File: rtl/fp32_defs.sv
// Shared FP32 field widths, limits and normalizer state encoding.
package fp32_defs;

  localparam int unsigned EXP_W      = 8;
  localparam int unsigned FRAC_W     = 23;
  localparam int unsigned GRS_W      = 3;
  localparam int unsigned MANT_IN_W  = 28;
  localparam int unsigned MANT_OUT_W = MANT_IN_W - 1;
  localparam int unsigned HID_BIT    = FRAC_W + GRS_W;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } fpn_state_t;

endpackage

// File: rtl/lzc28.sv
// Combinational leading-zero count over the hidden bit and below (27 bits).
module lzc28 (
  input  logic [26:0] in_bits,
  output logic [4:0]  count
);

  logic found;

  always_comb begin
    count = 5'd27;
    found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!found && in_bits[26-i]) begin
        count = 5'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_normalize32.sv
// FP32 post-add normalizer: carry right-shift or iterative left-shift to restore the hidden bit.
// Define FPN_LZC_EN for a single-cycle leading-zero-count barrel shift instead of the SHIFT loop.
module fp_normalize32
  import fp32_defs::*;
#(
  parameter real         T          = 0.0,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [MANT_IN_W-1:0]  in_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_W-1:0]      out_exp,
  output logic [MANT_OUT_W-1:0] out_mant,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic                  out_unf
);

  if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4) || T < 0.0) begin : g_bad_param
    $error("fp_normalize32: SHIFT_STEP must be 1, 2 or 4 and T must be non-negative");
  end

  fpn_state_t           state, state_nx;
  logic                 sign_r, sign_nx;
  logic [EXP_W:0]       exp_r, exp_nx;
  logic [MANT_IN_W-1:0] mant_r, mant_nx;
  logic                 zero_r, zero_nx;
  logic                 ovf_r, ovf_nx;
  logic                 unf_r, unf_nx;

  logic [4:0]           lz;
  logic [4:0]           shamt;
  logic [EXP_W:0]       exp_m1;
  logic [EXP_W:0]       exp_inc;
  logic [EXP_W:0]       exp_shl;
  logic [MANT_IN_W-1:0] mant_shl;
  logic                 take_shift;

`ifdef FPN_LZC_EN
  lzc28 u_lzc (
    .in_bits (mant_r[HID_BIT:0]),
    .count   (lz)
  );
`else
  logic lz_run;

  // Leading zeros among the top SHIFT_STEP bits only, saturating at SHIFT_STEP.
  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int unsigned i = 0; i < SHIFT_STEP; i++) begin
      if (lz_run && !mant_r[HID_BIT-i]) lz = 5'(i + 1);
      else                              lz_run = 1'b0;
    end
  end
`endif

  // Never shift the exponent below 1; exp_m1 is only used once exp_r >= 2.
  assign exp_m1   = exp_r - 9'd1;
  assign shamt    = ({4'b0, lz} > exp_m1) ? exp_m1[4:0] : lz;
  assign mant_shl = mant_r << shamt;
  assign exp_shl  = exp_r - {4'b0, shamt};
  assign exp_inc  = exp_r + 9'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sign_r <= 1'b0;
      exp_r  <= '0;
      mant_r <= '0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      state  <= state_nx;
      sign_r <= sign_nx;
      exp_r  <= exp_nx;
      mant_r <= mant_nx;
      zero_r <= zero_nx;
      ovf_r  <= ovf_nx;
      unf_r  <= unf_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sign_nx    = sign_r;
    exp_nx     = exp_r;
    mant_nx    = mant_r;
    zero_nx    = zero_r;
    ovf_nx     = ovf_r;
    unf_nx     = unf_r;
    take_shift = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          sign_nx  = in_sign;
          exp_nx   = {1'b0, in_exp};
          mant_nx  = in_mant;
          zero_nx  = 1'b0;
          ovf_nx   = 1'b0;
          unf_nx   = 1'b0;
          state_nx = S_EVAL;
        end
      end
      S_EVAL: begin
        if (mant_r == '0) begin
          exp_nx   = '0;
          zero_nx  = 1'b1;
          state_nx = S_DONE;
        end else if (mant_r[MANT_IN_W-1]) begin
          if (exp_inc >= {1'b0, EXP_MAX}) begin
            exp_nx  = {1'b0, EXP_MAX};
            mant_nx = '0;
            ovf_nx  = 1'b1;
          end else begin
            exp_nx  = exp_inc;
            mant_nx = {1'b0, mant_r[MANT_IN_W-1:2], mant_r[1] | mant_r[0]};
          end
          state_nx = S_DONE;
        end else if (mant_r[HID_BIT]) begin
          state_nx = S_DONE;
        end else if (exp_r <= 9'd1) begin
          exp_nx   = '0;
          unf_nx   = 1'b1;
          state_nx = S_DONE;
        end else begin
`ifdef FPN_LZC_EN
          take_shift = 1'b1;
`else
          state_nx = S_SHIFT;
`endif
        end
      end
      S_SHIFT: take_shift = 1'b1;
      S_DONE: begin
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Shared by the LZC barrel shift in EVAL and each iterative SHIFT step.
    if (take_shift) begin
      mant_nx = mant_shl;
      if (mant_shl[HID_BIT]) begin
        exp_nx   = exp_shl;
        state_nx = S_DONE;
      end else if (exp_shl == 9'd1) begin
        exp_nx   = '0;
        unf_nx   = 1'b1;
        state_nx = S_DONE;
      end else begin
        exp_nx   = exp_shl;
        state_nx = S_SHIFT;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign out_sign  = sign_r;
  assign out_exp   = exp_r[EXP_W-1:0];
  assign out_mant  = mant_r[MANT_OUT_W-1:0];
  assign out_zero  = zero_r;
  assign out_ovf   = ovf_r;
  assign out_unf   = unf_r;

endmodule

// File: tb/tb_fp_normalize32.sv
// Bench for fp_normalize32: directed vector table, handshake/reset sequences, randomized ops vs arithmetic model.
module tb_fp_normalize32;

  localparam int unsigned STEP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [26:0] out_mant;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  always #5 clk = ~clk;

  fp_normalize32 #(.T(0.0), .SHIFT_STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  typedef struct {
    bit          sign;
    logic [7:0]  exp;
    logic [26:0] mant;
    bit          zero;
    bit          ovf;
    bit          unf;
    int          lat;
  } res_t;

  typedef struct {
    bit          sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    res_t        want;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int lat_for(input int unsigned steps);
`ifdef FPN_LZC_EN
    return 2 + 0 * int'(steps);
`else
    return 2 + int'((steps + STEP - 1) / STEP);
`endif
  endfunction

  // Normalization from the arithmetic rules: find the MSB, shift it to bit 26 unless the exponent runs out.
  function automatic res_t model(input bit s, input int unsigned e, input int unsigned m);
    res_t r;
    int unsigned msb, k, avail, steps;
    r.sign = s; r.zero = 1'b0; r.ovf = 1'b0; r.unf = 1'b0; steps = 0;
    r.exp = '0; r.mant = '0;
    if (m == 0) begin
      r.zero = 1'b1;
    end else if (m >= 32'h800_0000) begin
      if (e + 1 >= 255) begin
        r.exp = 8'hFF; r.ovf = 1'b1;
      end else begin
        r.exp  = 8'(e + 1);
        r.mant = 27'((m >> 1) | (m & 1));
      end
    end else begin
      msb = 0;
      for (int b = 0; b < 27; b++) if (m >= (32'd1 << b)) msb = b;
      k = 26 - msb;
      avail = (e == 0) ? 0 : e - 1;
      if (k <= avail) begin
        r.mant = 27'(m << k); r.exp = 8'(e - k); steps = k;
      end else begin
        r.mant = 27'(m << avail); r.exp = '0; r.unf = 1'b1; steps = avail;
      end
    end
    r.lat = lat_for(steps);
    return r;
  endfunction

  function automatic vec_t mkv(input bit s, input logic [7:0] e, input logic [27:0] m,
                               input logic [7:0] we, input logic [26:0] wm,
                               input bit z, input bit o, input bit u, input int unsigned k);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m;
    v.want.sign = s; v.want.exp = we; v.want.mant = wm;
    v.want.zero = z; v.want.ovf = o; v.want.unf = u;
    v.want.lat = lat_for(k);
    return v;
  endfunction

  task automatic cmp(input string tag, input res_t got, input res_t want);
    chk({tag, ".sign"}, 64'(got.sign), 64'(want.sign));
    chk({tag, ".exp"},  64'(got.exp),  64'(want.exp));
    chk({tag, ".mant"}, 64'(got.mant), 64'(want.mant));
    chk({tag, ".zero"}, 64'(got.zero), 64'(want.zero));
    chk({tag, ".ovf"},  64'(got.ovf),  64'(want.ovf));
    chk({tag, ".unf"},  64'(got.unf),  64'(want.unf));
    chk({tag, ".lat"},  64'(got.lat),  64'(want.lat));
  endtask

  // Issue one operand, measure capture-to-valid latency, optionally stall in DONE, then retire.
  task automatic run_op(input bit s, input logic [7:0] e, input logic [27:0] m,
                        input int hold, output res_t got);
    int w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got.lat = 1;
    while (!out_valid && got.lat < 200) begin @(posedge clk); #1; got.lat++; end
    chk("out_valid_reached", 64'(out_valid), 64'd1);
    got.sign = out_sign; got.exp = out_exp; got.mant = out_mant;
    got.zero = out_zero; got.ovf = out_ovf; got.unf = out_unf;
    if (hold > 0) begin
      in_valid = 1'b1; in_sign = ~s; in_exp = ~e; in_mant = 28'h0A5A5A5;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold.out_valid", 64'(out_valid), 64'd1);
      chk("hold.in_ready",  64'(in_ready),  64'd0);
      chk("hold.data", {out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf},
                       {got.sign, got.exp, got.mant, got.zero, got.ovf, got.unf});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retire.in_ready",  64'(in_ready),  64'd1);
    chk("retire.out_valid", 64'(out_valid), 64'd0);
  endtask

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t got, want;
    bit          s;
    logic [7:0]  e;
    logic [27:0] m;

    vecs[0]  = mkv(0, 8'h7F, 28'h4000000, 8'h7F, 27'h4000000, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 8'h80, 28'h8000001, 8'h81, 27'h4000001, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 8'h7F, 28'h0000008, 8'h68, 27'h4000000, 0, 0, 0, 23);
    vecs[3]  = mkv(0, 8'h03, 28'h0100000, 8'h00, 27'h0400000, 0, 0, 1, 2);
    vecs[4]  = mkv(0, 8'hFE, 28'h8000000, 8'hFF, 27'h0000000, 0, 1, 0, 0);
    vecs[5]  = mkv(1, 8'h55, 28'h0000000, 8'h00, 27'h0000000, 1, 0, 0, 0);
    vecs[6]  = mkv(0, 8'h01, 28'h0000001, 8'h00, 27'h0000001, 0, 0, 1, 0);
    vecs[7]  = mkv(0, 8'h1B, 28'h0000001, 8'h01, 27'h4000000, 0, 0, 0, 26);
    vecs[8]  = mkv(0, 8'hFD, 28'h8000003, 8'hFE, 27'h4000001, 0, 0, 0, 0);
    vecs[9]  = mkv(1, 8'h00, 28'h2000000, 8'h00, 27'h2000000, 0, 0, 1, 0);
    vecs[10] = mkv(0, 8'h1A, 28'h0000001, 8'h00, 27'h2000000, 0, 0, 1, 25);
    vecs[11] = mkv(1, 8'h90, 28'h7FFFFFF, 8'h90, 27'h7FFFFFF, 0, 0, 0, 0);
    vecs[12] = mkv(0, 8'h7F, 28'h1234567, 8'h7D, 27'h48D159C, 0, 0, 0, 2);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready",  64'(in_ready),  64'd1);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.data", {out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].sign, vecs[i].exp, vecs[i].mant, 0, got);
      cmp($sformatf("vec%0d", i), got, vecs[i].want);
    end

    // Stall in DONE for 5 cycles with a competing operand on the input.
    run_op(vecs[1].sign, vecs[1].exp, vecs[1].mant, 5, got);
    cmp("stall", got, vecs[1].want);
    run_op(vecs[0].sign, vecs[0].exp, vecs[0].mant, 0, got);
    cmp("after_stall", got, vecs[0].want);

    // Asynchronous reset in the middle of a deep shift.
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 28'h0000008;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("midop.busy", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midop_rst.out_valid", 64'(out_valid), 64'd0);
    chk("midop_rst.in_ready",  64'(in_ready),  64'd1);
    chk("midop_rst.data", {out_sign, out_exp, out_mant, out_zero, out_ovf, out_unf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(vecs[2].sign, vecs[2].exp, vecs[2].mant, 0, got);
    cmp("post_rst", got, vecs[2].want);

    // Randomized operands against the arithmetic model.
    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom_range(0, 1));
      m = 28'($urandom()) >> $urandom_range(0, 28);
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(0, 4));
        1:       e = 8'($urandom_range(250, 254));
        default: e = 8'($urandom_range(0, 254));
      endcase
      if ($urandom_range(0, 15) == 0) m = '0;
      if ($urandom_range(0, 7) == 0)  m = m | 28'h8000000;
      want = model(s, 32'(e), 32'(m));
      run_op(s, e, m, int'($urandom_range(0, 2)), got);
      cmp($sformatf("rnd%0d", n), got, want);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
